// File: rtl/text_region_engine.sv
`default_nettype none
// ============================================================================
// Module   : text_region_engine
// Brief    : Executes one text-buffer edit command (fill, insert/delete
//            character, scroll up/down) against a line-organised text RAM
//            using read-modify-write and row-copy cycles.
// Revision : 1.0 - initial release
// ============================================================================
module text_region_engine #(
  parameter int                COLS   = 80,
  parameter int                ROWS   = 25,
  parameter int                CHAR_W = 32,
  parameter int                POS_W  = 8,
  parameter logic [CHAR_W-1:0] BLANK  = 32'h0007fc20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [POS_W-1:0]         cmd_row0,
  input  logic [POS_W-1:0]         cmd_row1,
  input  logic [POS_W-1:0]         cmd_col0,
  input  logic [POS_W-1:0]         cmd_col1,
  input  logic [POS_W-1:0]         cmd_n,
  input  logic [CHAR_W-1:0]        cmd_data,
  output logic [POS_W-1:0]         ram_addr,
  output logic                     ram_wren,
  output logic [COLS*CHAR_W-1:0]   ram_wdata,
  input  logic [COLS*CHAR_W-1:0]   ram_rdata,
  output logic                     busy,
  output logic                     done
);

  localparam int               LW        = COLS * CHAR_W;
  localparam logic [2:0]       c_OP_FILL  = 3'd0;
  localparam logic [2:0]       c_OP_INSCH = 3'd1;
  localparam logic [2:0]       c_OP_DELCH = 3'd2;
  localparam logic [2:0]       c_OP_SCRUP = 3'd3;
  localparam logic [2:0]       c_OP_SCRDN = 3'd4;
  localparam logic [POS_W-1:0] c_ROW_MAX = POS_W'(ROWS - 1);
  localparam logic [POS_W-1:0] c_COL_MAX = POS_W'(COLS - 1);
  localparam logic [POS_W:0]   c_ONE     = (POS_W+1)'(1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD     = 4'd1,
    S_W1     = 4'd2,
    S_W2     = 4'd3,
    S_WR     = 4'd4,
    S_BLK_WR = 4'd5,
    S_CP_RD  = 4'd6,
    S_CP_W1  = 4'd7,
    S_CP_W2  = 4'd8,
    S_CP_WR  = 4'd9,
    S_DONE   = 4'd10
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [2:0]          r_op;
  logic [POS_W-1:0]    r_col0;
  logic [POS_W-1:0]    r_col1;
  logic [POS_W-1:0]    r_n;
  logic [CHAR_W-1:0]   r_data;
  logic [CHAR_W-1:0]   r_fillv;
  logic                r_dn;
  logic [POS_W:0]      r_cur;   // destination row of the current step
  logic [POS_W:0]      r_cp;    // row copies still to do
  logic [POS_W:0]      r_bk;    // RMW rows or blank/direct writes still to do
  logic [LW-1:0]       r_line;

  logic                w_accept;
  logic [POS_W-1:0]    w_row1;
  logic [POS_W-1:0]    w_col1;
  logic [POS_W-1:0]    w_n;
  logic [POS_W:0]      w_n9;
  logic [POS_W:0]      w_h;
  logic [POS_W:0]      w_copies;
  logic [POS_W:0]      w_blanks;
  logic                w_empty;
  logic                w_fast;
  logic                w_scroll;
  logic [POS_W:0]      w_src;
  logic [POS_W:0]      w_step;
  logic [LW-1:0]       w_mod;
  logic                w_unused;

  // Field normalisation and region sizing, evaluated on the accept cycle
  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_row1   = (cmd_row1 > c_ROW_MAX) ? c_ROW_MAX : cmd_row1;
  assign w_col1   = (cmd_col1 > c_COL_MAX) ? c_COL_MAX : cmd_col1;
  assign w_n      = (cmd_n == '0) ? POS_W'(1) : cmd_n;
  assign w_n9     = {1'b0, w_n};
  assign w_h      = {1'b0, w_row1} - {1'b0, cmd_row0} + c_ONE;
  assign w_copies = (w_h > w_n9) ? (w_h - w_n9) : '0;
  assign w_blanks = (w_h > w_n9) ? w_n9 : w_h;
  assign w_scroll = (cmd_op == c_OP_SCRUP) || (cmd_op == c_OP_SCRDN);
  assign w_fast   = (cmd_col0 == '0) && (w_col1 == c_COL_MAX);
  assign w_empty  = (cmd_op > c_OP_SCRDN) || (cmd_row0 > w_row1) ||
                    ((cmd_op == c_OP_FILL) && (cmd_col0 > w_col1));

  // Copy source lies n rows beyond the destination, away from the scroll direction
  assign w_src    = r_dn ? (r_cur - {1'b0, r_n}) : (r_cur + {1'b0, r_n});
  assign w_step   = r_dn ? (r_cur - c_ONE) : (r_cur + c_ONE);
  assign w_unused = ^{w_src[POS_W], r_cur[POS_W]};

  // Line modification for the RMW write: masked fill or single-cycle shift
  always_comb begin
    int c0;
    int c1;
    int n;
    w_mod = r_line;
    c0 = int'(r_col0);
    c1 = int'(r_col1);
    n  = int'(r_n);
    for (int c = 0; c < COLS; c++) begin
      case (r_op)
        c_OP_FILL: begin
          if (c >= c0 && c <= c1) w_mod[c*CHAR_W +: CHAR_W] = r_data;
        end
        c_OP_INSCH: begin
          if (c >= c0) begin
            if (c < c0 + n) w_mod[c*CHAR_W +: CHAR_W] = BLANK;
            else            w_mod[c*CHAR_W +: CHAR_W] = r_line[(c-n)*CHAR_W +: CHAR_W];
          end
        end
        c_OP_DELCH: begin
          if (c >= c0) begin
            if (c + n < COLS) w_mod[c*CHAR_W +: CHAR_W] = r_line[(c+n)*CHAR_W +: CHAR_W];
            else              w_mod[c*CHAR_W +: CHAR_W] = BLANK;
          end
        end
        default: ;
      endcase
    end
  end

  // State register; reset aborts any command in flight
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and RAM port drive
  always_comb begin
    w_next    = r_state;
    ram_addr  = '0;
    ram_wren  = 1'b0;
    ram_wdata = '0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept) begin
          if (w_empty)                            w_next = S_DONE;
          else if (w_scroll)                      w_next = (w_copies != '0) ? S_CP_RD : S_BLK_WR;
          else if (cmd_op == c_OP_FILL && w_fast) w_next = S_BLK_WR;
          else                                    w_next = S_RD;
        end
      end
      S_RD: begin
        ram_addr = r_cur[POS_W-1:0];
        w_next   = S_W1;
      end
      S_W1: begin
        ram_addr = r_cur[POS_W-1:0];
        w_next   = S_W2;
      end
      S_W2: begin
        ram_addr = r_cur[POS_W-1:0];
        w_next   = S_WR;
      end
      S_WR: begin
        ram_addr  = r_cur[POS_W-1:0];
        ram_wren  = 1'b1;
        ram_wdata = w_mod;
        w_next    = (r_bk == c_ONE) ? S_DONE : S_RD;
      end
      S_CP_RD: begin
        ram_addr = w_src[POS_W-1:0];
        w_next   = S_CP_W1;
      end
      S_CP_W1: begin
        ram_addr = w_src[POS_W-1:0];
        w_next   = S_CP_W2;
      end
      S_CP_W2: begin
        ram_addr = w_src[POS_W-1:0];
        w_next   = S_CP_WR;
      end
      S_CP_WR: begin
        ram_addr  = r_cur[POS_W-1:0];
        ram_wren  = 1'b1;
        ram_wdata = r_line;
        w_next    = (r_cp == c_ONE) ? S_BLK_WR : S_CP_RD;
      end
      S_BLK_WR: begin
        ram_addr  = r_cur[POS_W-1:0];
        ram_wren  = 1'b1;
        ram_wdata = {COLS{r_fillv}};
        w_next    = (r_bk == c_ONE) ? S_DONE : S_BLK_WR;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, row walking counters and read-line capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_col0  <= '0;
      r_col1  <= '0;
      r_n     <= '0;
      r_data  <= '0;
      r_fillv <= '0;
      r_dn    <= 1'b0;
      r_cur   <= '0;
      r_cp    <= '0;
      r_bk    <= '0;
      r_line  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= cmd_op;
            r_col0  <= cmd_col0;
            r_col1  <= w_col1;
            r_n     <= w_n;
            r_data  <= cmd_data;
            r_fillv <= (cmd_op == c_OP_FILL) ? cmd_data : BLANK;
            r_dn    <= (cmd_op == c_OP_SCRDN);
            r_cur   <= (cmd_op == c_OP_SCRDN) ? {1'b0, w_row1} : {1'b0, cmd_row0};
            r_cp    <= w_scroll ? w_copies : '0;
            if (w_scroll)                    r_bk <= w_blanks;
            else if (cmd_op == c_OP_FILL)    r_bk <= w_h;
            else                             r_bk <= c_ONE;
          end
        end
        S_W2, S_CP_W2: r_line <= ram_rdata;
        S_WR, S_BLK_WR: begin
          r_cur <= w_step;
          r_bk  <= r_bk - c_ONE;
        end
        S_CP_WR: begin
          r_cur <= w_step;
          r_cp  <= r_cp - c_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_text_region_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_region_engine
// Brief    : Self-checking bench for text_region_engine with a 2-cycle-latency
//            RAM model, a cell-level reference image and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_region_engine;

  localparam int          COLS   = 80;
  localparam int          ROWS   = 25;
  localparam int          CHAR_W = 32;
  localparam int          POS_W  = 8;
  localparam logic [31:0] BLANK  = 32'h0007fc20;
  localparam int          LW     = COLS * CHAR_W;

  typedef logic [LW-1:0]     line_t;
  typedef logic [CHAR_W-1:0] cell_t;

  typedef struct {
    logic [2:0]  op;
    int          row0, row1, col0, col1, n;
    logic [31:0] data;
    int          lat, wr, nowr;
  } vec_t;

  typedef struct {
    int lat, wr, nowr;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [POS_W-1:0]   cmd_row0, cmd_row1, cmd_col0, cmd_col1, cmd_n;
  logic [CHAR_W-1:0]  cmd_data;
  logic [POS_W-1:0]   ram_addr;
  logic               ram_wren;
  line_t              ram_wdata;
  line_t              ram_rdata;
  logic               busy;
  logic               done;

  line_t ram [ROWS];
  line_t shd [ROWS];
  line_t rd_p1;
  logic  tb_load;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  text_region_engine #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .POS_W(POS_W), .BLANK(BLANK)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row0(cmd_row0), .cmd_row1(cmd_row1),
    .cmd_col0(cmd_col0), .cmd_col1(cmd_col1),
    .cmd_n(cmd_n), .cmd_data(cmd_data),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cell_t pat(int r, int c);
    return cell_t'(32'hA500_0000 | (r << 16) | c);
  endfunction

  function automatic line_t pat_line(int r);
    line_t l;
    for (int c = 0; c < COLS; c++) l[c*CHAR_W +: CHAR_W] = pat(r, c);
    return l;
  endfunction

  function automatic cell_t cell_of(line_t l, int c);
    return l[c*CHAR_W +: CHAR_W];
  endfunction

  function automatic line_t fill_line(cell_t v);
    line_t l;
    for (int c = 0; c < COLS; c++) l[c*CHAR_W +: CHAR_W] = v;
    return l;
  endfunction

  // RAM model: write on wren, read data two cycles after the address
  always @(posedge clk) begin
    if (tb_load) begin
      for (int r = 0; r < ROWS; r++) ram[r] <= pat_line(r);
    end else if (ram_wren && int'(ram_addr) < ROWS) begin
      ram[int'(ram_addr)] <= ram_wdata;
    end
    rd_p1     <= (int'(ram_addr) < ROWS) ? ram[int'(ram_addr)] : '0;
    ram_rdata <= rd_p1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_ram(input string name);
    int first_bad;
    first_bad = -1;
    for (int r = ROWS - 1; r >= 0; r--) if (ram[r] !== shd[r]) first_bad = r;
    check({name, " first differing row"}, 64'(first_bad), 64'(-1));
  endtask

  // Reference model of the edit on the shadow image, built from cell/row lists
  task automatic apply_model(input vec_t v);
    int    r1, c1, n, h;
    cell_t q[$];
    line_t lq[$];
    line_t old, nl;
    r1 = (v.row1 > ROWS - 1) ? ROWS - 1 : v.row1;
    c1 = (v.col1 > COLS - 1) ? COLS - 1 : v.col1;
    n  = (v.n == 0) ? 1 : v.n;
    if (v.op > 3'd4 || v.row0 > r1) return;
    h = r1 - v.row0 + 1;
    case (v.op)
      3'd0: begin
        if (v.col0 > c1) return;
        for (int r = v.row0; r <= r1; r++)
          for (int c = v.col0; c <= c1; c++) shd[r][c*CHAR_W +: CHAR_W] = v.data;
      end
      3'd1, 3'd2: begin
        old = shd[v.row0];
        for (int c = 0; c < v.col0; c++) q.push_back(cell_of(old, c));
        if (v.op == 3'd1) begin
          for (int k = 0; k < n; k++) q.push_back(BLANK);
          for (int c = v.col0; c < COLS; c++) q.push_back(cell_of(old, c));
        end else begin
          for (int c = v.col0 + n; c < COLS; c++) q.push_back(cell_of(old, c));
          while (q.size() < COLS) q.push_back(BLANK);
        end
        for (int c = 0; c < COLS; c++) nl[c*CHAR_W +: CHAR_W] = q[c];
        shd[v.row0] = nl;
      end
      3'd3: begin
        for (int r = v.row0 + n; r <= r1; r++) lq.push_back(shd[r]);
        while (lq.size() < h) lq.push_back(fill_line(BLANK));
        for (int i = 0; i < h; i++) shd[v.row0 + i] = lq[i];
      end
      default: begin
        for (int k = 0; k < ((n < h) ? n : h); k++) lq.push_back(fill_line(BLANK));
        for (int r = v.row0; r <= r1 - n; r++) lq.push_back(shd[r]);
        for (int i = 0; i < h; i++) shd[v.row0 + i] = lq[i];
      end
    endcase
  endtask

  task automatic drive(input vec_t v);
    cmd_op   = v.op;
    cmd_row0 = POS_W'(v.row0);
    cmd_row1 = POS_W'(v.row1);
    cmd_col0 = POS_W'(v.col0);
    cmd_col1 = POS_W'(v.col1);
    cmd_n    = POS_W'(v.n);
    cmd_data = v.data;
  endtask

  // Issue one command and wait until the engine is ready
  task automatic issue(input vec_t v);
    int g;
    @(negedge clk);
    drive(v);
    cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!cmd_ready) check("ready wait timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run a command; count cycles up to done, writes, and non-write busy cycles
  task automatic run_cmd(input vec_t v, output int lat, output int wr, output int nowr);
    int k;
    issue(v);
    cmd_valid = 1'b0;
    lat = -1; wr = 0; nowr = 0;
    k = 1;
    while (k < 300) begin
      if (done) begin
        lat = k;
        break;
      end
      if (ram_wren) wr++;
      else          nowr++;
      k++;
      @(negedge clk);
    end
  endtask

  vec_t tbl [13];

  initial begin
    int   lat, wr, nowr;
    exp_t e;
    vec_t va, vb, vf;

    //           op   r0  r1  c0   c1   n    data            lat wr nowr
    tbl[0]  = '{3'd0,  2,  3,  5,   9,   0, 32'h0001_0041,    9,  2, 6};
    tbl[1]  = '{3'd1,  4,  4, 10,   0,   3, 32'h0,            5,  1, 3};
    tbl[2]  = '{3'd2,  4,  4, 10,   0, 100, 32'h0,            5,  1, 3};
    tbl[3]  = '{3'd3,  5,  9,  0,   0,   2, 32'h0,           15,  5, 9};
    tbl[4]  = '{3'd4,  5,  9,  0,   0,   7, 32'h0,            6,  5, 0};
    tbl[5]  = '{3'd0, 10, 12,  0,  79,   0, 32'h0BAD_F00D,    4,  3, 0};
    tbl[6]  = '{3'd0, 13, 13, 70, 200,   0, 32'h0000_0777,    5,  1, 3};
    tbl[7]  = '{3'd4, 20, 30,  0,   0,   3, 32'h0,           12,  5, 6};
    tbl[8]  = '{3'd6,  0,  5,  0,  10,   1, 32'h0,            1,  0, 0};
    tbl[9]  = '{3'd0,  0,  5,  9,   3,   1, 32'h1,            1,  0, 0};
    tbl[10] = '{3'd2, 15, 15,  0,   0,   0, 32'h0,            5,  1, 3};
    tbl[11] = '{3'd3,  0,  1,  0,   0,   1, 32'h0,            6,  2, 3};
    tbl[12] = '{3'd0,  0, 24,  0,  79,   0, 32'h1234_5678,   26, 25, 0};

    rst = 1'b1; tb_load = 1'b1; cmd_valid = 1'b0;
    drive(tbl[0]);
    for (int r = 0; r < ROWS; r++) shd[r] = pat_line(r);
    repeat (3) @(negedge clk);
    tb_load = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("reset ram_addr",  64'(ram_addr),  64'd0);
    check("reset ram_wren",  64'(ram_wren),  64'd0);
    check("reset ram_wdata", 64'(ram_wdata == '0), 64'd1);
    check("reset cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset busy",      64'(busy),      64'd0);
    check("reset done",      64'(done),      64'd0);

    for (int i = 0; i < 13; i++) begin
      sb.push_back('{tbl[i].lat, tbl[i].wr, tbl[i].nowr});
      apply_model(tbl[i]);
      run_cmd(tbl[i], lat, wr, nowr);
      e = sb.pop_front();
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(e.lat));
      check($sformatf("vec%0d writes", i), 64'(wr), 64'(e.wr));
      check($sformatf("vec%0d non-write cycles", i), 64'(nowr), 64'(e.nowr));
      compare_ram($sformatf("vec%0d", i));
      if (i == 0) begin
        check("fill r2 c5", 64'(cell_of(ram[2], 5)), 64'h0001_0041);
        check("fill r2 c4", 64'(cell_of(ram[2], 4)), 64'(pat(2, 4)));
        check("fill r3 c9", 64'(cell_of(ram[3], 9)), 64'h0001_0041);
        check("fill r3 c10", 64'(cell_of(ram[3], 10)), 64'(pat(3, 10)));
      end
      if (i == 1) begin
        check("insch c10", 64'(cell_of(ram[4], 10)), 64'(BLANK));
        check("insch c12", 64'(cell_of(ram[4], 12)), 64'(BLANK));
        check("insch c13", 64'(cell_of(ram[4], 13)), 64'(pat(4, 10)));
        check("insch c79", 64'(cell_of(ram[4], 79)), 64'(pat(4, 76)));
      end
      if (i == 2) begin
        check("delch c9",  64'(cell_of(ram[4], 9)),  64'(pat(4, 9)));
        check("delch c10", 64'(cell_of(ram[4], 10)), 64'(BLANK));
        check("delch c79", 64'(cell_of(ram[4], 79)), 64'(BLANK));
      end
      if (i == 3) begin
        check("scrup row5", 64'(ram[5] === pat_line(7)), 64'd1);
        check("scrup row7", 64'(ram[7] === pat_line(9)), 64'd1);
        check("scrup row8", 64'(ram[8] === fill_line(BLANK)), 64'd1);
        check("scrup row10", 64'(ram[10] === pat_line(10)), 64'd1);
      end
      if (i == 12) check("full fill row24", 64'(ram[24] === fill_line(32'h1234_5678)), 64'd1);
    end

    // Back-to-back: valid held high; second command is an empty region
    va = '{3'd2, 16, 16, 0, 0, 0, 32'h0, 5, 1, 3};
    vb = '{3'd0,  6,  3, 0, 5, 1, 32'h5, 1, 0, 0};
    issue(va);
    drive(vb);
    begin
      int k;
      k = 1;
      while (!done && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("b2b first latency", 64'(k), 64'd5);
    end
    check("b2b ready low in DONE", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("b2b ready after DONE", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    check("b2b empty done", 64'(done), 64'd1);
    check("b2b empty no write", 64'(ram_wren), 64'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b idle ready", 64'(cmd_ready), 64'd1);
    apply_model(va);
    compare_ram("b2b");

    // Reset during W1 of the second row of a partial FILL
    vf = '{3'd0, 1, 2, 0, 3, 0, 32'hDEAD_BEEF, 9, 2, 6};
    issue(vf);
    cmd_valid = 1'b0;
    begin
      int wcnt, dcnt;
      wcnt = 0; dcnt = 0;
      for (int k = 1; k <= 6; k++) begin
        if (ram_wren) wcnt++;
        if (done) dcnt++;
        if (k < 6) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort writes before reset", 64'(wcnt), 64'd1);
      check("abort no done", 64'(dcnt), 64'd0);
    end
    check("abort cmd_ready", 64'(cmd_ready), 64'd1);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort ram_wren", 64'(ram_wren), 64'd0);
    check("abort ram_addr", 64'(ram_addr), 64'd0);
    check("abort ram_wdata", 64'(ram_wdata == '0), 64'd1);
    vf.row1 = 1;
    apply_model(vf);
    begin
      int dcnt;
      dcnt = 0;
      repeat (5) begin
        @(negedge clk);
        if (done || ram_wren) dcnt++;
      end
      check("abort stays quiet", 64'(dcnt), 64'd0);
    end
    compare_ram("abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
